// File: rtl/grp_16_spi_pkg.sv
// Shared types and constants for the SPI minion physical stage.
package grp_16_spi_pkg;

    localparam int SPI_NBITS = 34;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_t;

    typedef logic [SPI_NBITS-1:0] spi_pkt_t;

endpackage

// File: rtl/grp_16_spi_minion_shifter_if.sv
// Pin side and adapter side of the SPI minion shifter grouped as one bundle.
interface grp_16_spi_minion_shifter_if
    import grp_16_spi_pkg::*;
#(
    parameter int NBITS = SPI_NBITS
);
    logic             spi_cs;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;
    logic             recv_val;
    logic [NBITS-1:0] recv_msg;
    logic             send_rdy;
    logic [NBITS-1:0] send_msg;
    logic             frame_err;
    logic             parity;

    modport slave (
        input  spi_cs, spi_sclk, spi_mosi, send_msg,
        output spi_miso, recv_val, recv_msg, send_rdy, frame_err, parity
    );

    modport master (
        output spi_cs, spi_sclk, spi_mosi, send_msg,
        input  spi_miso, recv_val, recv_msg, send_rdy, frame_err, parity
    );
endinterface

// File: rtl/grp_16_spi_pin_sync.sv
// Multi-flop pin synchroniser with one history flop for edge detection.
module grp_16_spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_s,
    output logic level_s,
    output logic rise_s,
    output logic fall_s
);
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser chain plus history flop, preset to the idle level of the pin.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{RST_VAL}};
            hist_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin_s};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level_s = sync_r[SYNC_STAGES-1];
    assign rise_s  = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign fall_s  = ~sync_r[SYNC_STAGES-1] & hist_r;
endmodule

// File: rtl/grp_16_spi_minion_shifter.sv
// SPI mode-0 minion shifter: one NBITS packet in and out per chip-select frame.
module grp_16_spi_minion_shifter
    import grp_16_spi_pkg::*;
#(
    parameter int NBITS       = SPI_NBITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    grp_16_spi_minion_shifter_if.slave   bus
);
    localparam int               CNT_W    = $clog2(NBITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBITS + 1);

    function automatic logic calc_parity(input logic [NBITS-1:0] v);
        return ^v;
    endfunction

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic mosi_level_s, mosi_rise_unused_s, mosi_fall_unused_s;

    spi_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [NBITS-1:0] rx_shift_r, rx_nxt_s;
    logic [NBITS-1:0] tx_shift_r, tx_nxt_s;
    logic [NBITS-1:0] recv_msg_r, recv_msg_nxt_s;
    logic             parity_r, parity_nxt_s;
    logic             recv_val_r, recv_val_nxt_s;
    logic             send_rdy_r, send_rdy_nxt_s;
    logic             frame_err_r, frame_err_nxt_s;
    logic             spi_miso_r, spi_miso_nxt_s;

    grp_16_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .pin_s(bus.spi_cs),
        .level_s(cs_level_s), .rise_s(cs_rise_s), .fall_s(cs_fall_s)
    );

    grp_16_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .pin_s(bus.spi_sclk),
        .level_s(sclk_level_s), .rise_s(sclk_rise_s), .fall_s(sclk_fall_s)
    );

    grp_16_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .pin_s(bus.spi_mosi),
        .level_s(mosi_level_s), .rise_s(mosi_rise_unused_s), .fall_s(mosi_fall_unused_s)
    );

    // Next-state and next-output logic; a cs rising edge pre-empts any sclk edge.
    // send_msg is loaded in the cycle send_rdy is high, so the strobe itself stays registered.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        rx_nxt_s        = rx_shift_r;
        tx_nxt_s        = tx_shift_r;
        recv_msg_nxt_s  = recv_msg_r;
        parity_nxt_s    = parity_r;
        recv_val_nxt_s  = 1'b0;
        send_rdy_nxt_s  = 1'b0;
        frame_err_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s    = ACTIVE;
                    count_nxt_s    = {CNT_W{1'b0}};
                    send_rdy_nxt_s = 1'b1;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_nxt_s = IDLE;
                    if (count_r == CNT_FULL) begin
                        recv_msg_nxt_s = rx_shift_r;
                        parity_nxt_s   = calc_parity(rx_shift_r);
                        recv_val_nxt_s = 1'b1;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                    end
                end else if (send_rdy_r) begin
                    tx_nxt_s = bus.send_msg;
                end else if (sclk_rise_s) begin
                    rx_nxt_s = {rx_shift_r[NBITS-2:0], mosi_level_s};
                    if (count_r == CNT_SAT) begin
                        count_nxt_s = count_r;
                    end else begin
                        count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (sclk_fall_s) begin
                    tx_nxt_s = {tx_shift_r[NBITS-2:0], 1'b0};
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (state_nxt_s == ACTIVE) begin
            spi_miso_nxt_s = tx_nxt_s[NBITS-1];
        end else begin
            spi_miso_nxt_s = 1'b0;
        end
    end

    // State, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            rx_shift_r  <= {NBITS{1'b0}};
            tx_shift_r  <= {NBITS{1'b0}};
            recv_msg_r  <= {NBITS{1'b0}};
            parity_r    <= 1'b0;
            recv_val_r  <= 1'b0;
            send_rdy_r  <= 1'b0;
            frame_err_r <= 1'b0;
            spi_miso_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            rx_shift_r  <= rx_nxt_s;
            tx_shift_r  <= tx_nxt_s;
            recv_msg_r  <= recv_msg_nxt_s;
            parity_r    <= parity_nxt_s;
            recv_val_r  <= recv_val_nxt_s;
            send_rdy_r  <= send_rdy_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            spi_miso_r  <= spi_miso_nxt_s;
        end
    end

    assign bus.spi_miso  = spi_miso_r;
    assign bus.recv_val  = recv_val_r;
    assign bus.recv_msg  = recv_msg_r;
    assign bus.send_rdy  = send_rdy_r;
    assign bus.frame_err = frame_err_r;
    assign bus.parity    = parity_r;
endmodule

// File: tb/tb_grp_16_spi_minion_shifter.sv
// Directed and randomized frames against a bit-queue model of the SPI minion shifter.
module tb_grp_16_spi_minion_shifter;
    import grp_16_spi_pkg::*;

    localparam int NB   = SPI_NBITS;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grp_16_spi_minion_shifter_if #(.NBITS(NB)) bus ();

    grp_16_spi_minion_shifter #(.NBITS(NB), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int rv_cnt   = 0;
    int sr_cnt   = 0;
    int fe_cnt   = 0;
    logic [NB-1:0] rx_log[$];
    logic          bit_q[$];
    logic [NB-1:0] exp_rx_m = '0;

    // Pulse monitor: counts every cycle each strobe is high.
    always @(negedge clk) begin
        if (bus.recv_val === 1'b1) begin
            rv_cnt++;
            rx_log.push_back(bus.recv_msg);
        end
        if (bus.send_rdy === 1'b1) sr_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Packs the bits received in the last frame, first bit ends up as MSB.
    function automatic logic [NB-1:0] model_pkt();
        logic [NB-1:0] v = '0;
        foreach (bit_q[i]) v = {v[NB-2:0], bit_q[i]};
        return v;
    endfunction

    // Master side of one mode-0 frame; called at a negedge with cs high.
    task automatic spi_frame(input int nbits, input logic [63:0] data, output logic [63:0] miso_bits);
        logic b;
        miso_bits = '0;
        bit_q.delete();
        bus.spi_cs = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            b = data[i];
            bus.spi_mosi = b;
            bit_q.push_back(b);
            clk_wait(HALF);
            miso_bits = {miso_bits[62:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            clk_wait(HALF);
            bus.spi_sclk = 1'b0;
        end
        clk_wait(HALF);
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int nbits, input logic [63:0] data,
                             input logic [NB-1:0] tx);
        int rv0 = rv_cnt;
        int sr0 = sr_cnt;
        int fe0 = fe_cnt;
        logic [63:0] mb;
        logic [63:0] exp_mb = '0;
        bus.send_msg = tx;
        spi_frame(nbits, data, mb);
        clk_wait(8);
        for (int k = 0; k < nbits; k++)
            exp_mb = {exp_mb[62:0], (k < NB) ? tx[NB-1-k] : 1'b0};
        check({tag, "_miso"}, mb, exp_mb);
        check({tag, "_send_rdy"}, 64'(sr_cnt - sr0), 64'd1);
        if (bit_q.size() == NB) begin
            exp_rx_m = model_pkt();
            check({tag, "_recv_val"}, 64'(rv_cnt - rv0), 64'd1);
            check({tag, "_frame_err"}, 64'(fe_cnt - fe0), 64'd0);
        end else begin
            check({tag, "_recv_val"}, 64'(rv_cnt - rv0), 64'd0);
            check({tag, "_frame_err"}, 64'(fe_cnt - fe0), 64'd1);
        end
        check({tag, "_recv_msg"}, 64'(bus.recv_msg), 64'(exp_rx_m));
        check({tag, "_parity"}, 64'(bus.parity), 64'(^exp_rx_m));
    endtask

    initial begin
        int rv0, sr0, fe0;
        logic          miso_or;
        logic [63:0]   mb_a, mb_b;
        logic [NB-1:0] tx_a, tx_b, dat_a, dat_b;

        reset = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.send_msg = '0;
        clk_wait(4);
        check("rst_miso", 64'(bus.spi_miso), 64'd0);
        check("rst_recv_val", 64'(bus.recv_val), 64'd0);
        check("rst_recv_msg", 64'(bus.recv_msg), 64'd0);
        check("rst_send_rdy", 64'(bus.send_rdy), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_parity", 64'(bus.parity), 64'd0);
        reset = 1'b1;
        clk_wait(6);

        run_frame("full", NB, 64'(34'h1_1234_5678), 34'h2_DEAD_BEEF);
        check("full_known_msg", 64'(bus.recv_msg), 64'(34'h1_1234_5678));
        run_frame("short", 20, {$urandom(), $urandom()}, NB'({$urandom(), $urandom()}));
        run_frame("long", 36, {$urandom(), $urandom()}, NB'({$urandom(), $urandom()}));
        run_frame("rand", NB, {$urandom(), $urandom()}, NB'({$urandom(), $urandom()}));

        // Abort a frame with reset after ten bits.
        rv0 = rv_cnt; sr0 = sr_cnt; fe0 = fe_cnt;
        bus.send_msg = NB'({$urandom(), $urandom()});
        bus.spi_cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.spi_mosi = 1'($urandom_range(1, 0));
            clk_wait(HALF);
            bus.spi_sclk = 1'b1;
            clk_wait(HALF);
            bus.spi_sclk = 1'b0;
        end
        reset = 1'b0;
        bus.spi_cs = 1'b1;
        clk_wait(3);
        check("abort_recv_msg", 64'(bus.recv_msg), 64'd0);
        check("abort_parity", 64'(bus.parity), 64'd0);
        check("abort_miso", 64'(bus.spi_miso), 64'd0);
        clk_wait(4);
        reset = 1'b1;
        clk_wait(10);
        check("abort_recv_val", 64'(rv_cnt - rv0), 64'd0);
        check("abort_frame_err", 64'(fe_cnt - fe0), 64'd0);
        check("abort_send_rdy", 64'(sr_cnt - sr0), 64'd1);
        exp_rx_m = '0;
        run_frame("after_rst", NB, {$urandom(), $urandom()}, NB'({$urandom(), $urandom()}));

        // sclk noise with cs high must be ignored.
        rv0 = rv_cnt; sr0 = sr_cnt; fe0 = fe_cnt;
        miso_or = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.spi_sclk = ~bus.spi_sclk;
            bus.spi_mosi = 1'($urandom_range(1, 0));
            clk_wait(2);
            miso_or = miso_or | bus.spi_miso;
        end
        bus.spi_sclk = 1'b0;
        clk_wait(8);
        check("idle_recv_val", 64'(rv_cnt - rv0), 64'd0);
        check("idle_send_rdy", 64'(sr_cnt - sr0), 64'd0);
        check("idle_frame_err", 64'(fe_cnt - fe0), 64'd0);
        check("idle_miso", 64'(miso_or), 64'd0);

        // Back-to-back frames with a four-cycle cs-high gap.
        rv0 = rv_cnt; sr0 = sr_cnt;
        tx_a = NB'({$urandom(), $urandom()});
        tx_b = NB'({$urandom(), $urandom()});
        dat_a = NB'({$urandom(), $urandom()});
        dat_b = NB'({$urandom(), $urandom()});
        bus.send_msg = tx_a;
        spi_frame(NB, 64'(dat_a), mb_a);
        clk_wait(4);
        bus.send_msg = tx_b;
        spi_frame(NB, 64'(dat_b), mb_b);
        clk_wait(8);
        check("b2b_recv_val", 64'(rv_cnt - rv0), 64'd2);
        check("b2b_send_rdy", 64'(sr_cnt - sr0), 64'd2);
        check("b2b_miso_a", mb_a, 64'(tx_a));
        check("b2b_miso_b", mb_b, 64'(tx_b));
        if (rx_log.size() >= rv0 + 2) begin
            check("b2b_msg_a", 64'(rx_log[rv0]), 64'(dat_a));
            check("b2b_msg_b", 64'(rx_log[rv0 + 1]), 64'(dat_b));
        end else begin
            check("b2b_msg_log", 64'(rx_log.size()), 64'(rv0 + 2));
        end
        check("b2b_parity", 64'(bus.parity), 64'(^dat_b));

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
